// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: operation codes
// used by the next-state mux and by benches driving the mode port.
package univ_shift_reg_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROTR = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROTL = 3'b101;
  localparam logic [MODE_W-1:0] MODE_JOHN = 3'b110;
  localparam logic [MODE_W-1:0] MODE_CNT  = 3'b111;

endpackage

// File: rtl/dff_cp_bit.sv
// One storage bit: async active-low clear, sync active-low preset to a
// per-bit constant, otherwise captures d every edge.
module dff_cp_bit #(
  parameter logic PRESET_BIT = 1'b1
) (
  input  logic clk,
  input  logic clr,
  input  logic pre,
  input  logic d,
  output logic q,
  output logic qn
);

  logic q_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)      q_q <= 1'b0;
    else if (!pre) q_q <= PRESET_BIT;
    else           q_q <= d;
  end

  assign q  = q_q;
  assign qn = ~q_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal register: hold, shift, load, rotate, Johnson step and count,
// built from WIDTH clear/preset flip-flops fed by one next-state mux.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] PRESET_VAL = '1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              pre,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin_r,
  input  logic              sin_l,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  qn,
  output logic              sout_r,
  output logic              sout_l,
  output logic              tc
);

  logic [WIDTH-1:0] q_d;

  // Clear and preset live inside each bit, so the mux only sees en and mode.
  always_comb begin
    q_d = q;
    if (en) begin
      case (mode)
        MODE_HOLD: q_d = q;
        MODE_SHR:  q_d = {sin_r, q[WIDTH-1:1]};
        MODE_SHL:  q_d = {q[WIDTH-2:0], sin_l};
        MODE_LOAD: q_d = d;
        MODE_ROTR: q_d = {q[0], q[WIDTH-1:1]};
        MODE_ROTL: q_d = {q[WIDTH-2:0], q[WIDTH-1]};
        MODE_JOHN: q_d = {~q[0], q[WIDTH-1:1]};
        MODE_CNT:  q_d = q + WIDTH'(1);
        default:   q_d = q;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_cp_bit #(
      .PRESET_BIT(PRESET_VAL[i])
    ) u_bit (
      .clk (clk),
      .clr (clr),
      .pre (pre),
      .d   (q_d[i]),
      .q   (q[i]),
      .qn  (qn[i])
    );
  end

  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];
  // Gating with clr keeps tc low during clear even before q has settled.
  assign tc     = clr & en & (mode == MODE_CNT) & (&q);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench: the driver predicts each post-edge state from plain
// arithmetic; a monitor pops predictions and compares after every edge.
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;

  logic       clk = 1'b0;
  logic       clr, pre, en, sin_r, sin_l;
  logic [2:0] mode;
  logic [7:0] d, q, qn;
  logic       sout_r, sout_l, tc;

  typedef struct {
    int    qv;
    bit    tcv;
    string tag;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   mq    = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8), .PRESET_VAL(8'hFF)) dut (
    .clk(clk), .clr(clr), .pre(pre), .en(en), .mode(mode), .d(d),
    .sin_r(sin_r), .sin_l(sin_l), .q(q), .qn(qn),
    .sout_r(sout_r), .sout_l(sout_l), .tc(tc)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: after each edge, compare outputs with the oldest prediction.
  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk({e.tag, " q"},      int'(q),      e.qv);
        chk({e.tag, " qn"},     int'(qn),     255 - e.qv);
        chk({e.tag, " sout_r"}, int'(sout_r), e.qv % 2);
        chk({e.tag, " sout_l"}, int'(sout_l), e.qv / 128);
        chk({e.tag, " tc"},     int'(tc),     int'(e.tcv));
      end
    end
  end

  task automatic step(input bit c, input bit p, input bit e, input logic [2:0] m,
                      input int dd, input bit sr, input bit sl, input string tag);
    int nq;
    bit was_hi;
    @(negedge clk);
    was_hi = clr;
    clr = c; pre = p; en = e; mode = m; d = dd[7:0]; sin_r = sr; sin_l = sl;
    if (!c)      nq = 0;
    else if (!p) nq = 255;
    else if (!e) nq = mq;
    else begin
      case (m)
        MODE_SHR:  nq = mq / 2 + int'(sr) * 128;
        MODE_SHL:  nq = (mq * 2) % 256 + int'(sl);
        MODE_LOAD: nq = dd % 256;
        MODE_ROTR: nq = mq / 2 + (mq % 2) * 128;
        MODE_ROTL: nq = (mq * 2) % 256 + mq / 128;
        MODE_JOHN: nq = mq / 2 + (1 - mq % 2) * 128;
        MODE_CNT:  nq = (mq + 1) % 256;
        default:   nq = mq;
      endcase
    end
    sbq.push_back('{nq, (c && e && m == MODE_CNT && nq == 255), tag});
    mq = nq;
    if (was_hi && !c) begin
      #1;
      chk({tag, " async q"},  int'(q),  0);
      chk({tag, " async tc"}, int'(tc), 0);
    end
    @(posedge clk);
  endtask

  initial begin
    clr = 1'b1; pre = 1'b1; en = 1'b1; mode = MODE_CNT; d = 8'h00;
    sin_r = 1'b0; sin_l = 1'b0;
    #1 clr = 1'b0;
    #2;
    chk("reset q",      int'(q),      0);
    chk("reset qn",     int'(qn),     255);
    chk("reset sout_r", int'(sout_r), 0);
    chk("reset sout_l", int'(sout_l), 0);
    chk("reset tc",     int'(tc),     0);

    step(0, 1, 1, MODE_CNT,  0,     0, 0, "in_reset");
    step(1, 1, 1, MODE_LOAD, 'hA5,  0, 0, "load_a5");
    step(0, 1, 1, MODE_CNT,  0,     0, 0, "clr_mid");
    step(1, 1, 1, MODE_LOAD, 'h3C,  0, 0, "load_3c");

    step(1, 1, 1, MODE_LOAD, 'h81,  0, 0, "load_81");
    step(1, 1, 1, MODE_SHR,  0,     1, 0, "shr");
    step(1, 1, 1, MODE_SHL,  0,     1, 0, "shl");

    step(1, 1, 1, MODE_LOAD, 'h01,  0, 0, "load_01");
    for (int i = 0; i < 8; i++) step(1, 1, 1, MODE_ROTR, 0, 0, 0, "rotr");
    step(1, 1, 1, MODE_ROTL, 0,     0, 0, "rotl");

    step(1, 1, 1, MODE_LOAD, 0,     0, 0, "load_00");
    for (int i = 0; i < 16; i++) step(1, 1, 1, MODE_JOHN, 0, 0, 0, "john");

    step(1, 1, 1, MODE_LOAD, 'hFE,  0, 0, "load_fe");
    step(1, 1, 1, MODE_CNT,  0,     0, 0, "cnt_ff");
    step(1, 1, 1, MODE_CNT,  0,     0, 0, "cnt_wrap");
    step(1, 1, 1, MODE_LOAD, 'hFF,  0, 0, "load_ff");
    step(1, 1, 0, MODE_CNT,  0,     0, 0, "en_off");

    step(1, 1, 1, MODE_LOAD, 'h00,  0, 0, "load_00b");
    step(1, 0, 1, MODE_LOAD, 'h12,  0, 0, "preset");
    step(0, 0, 1, MODE_LOAD, 'h12,  0, 0, "pre_clr");

    for (int i = 0; i < 400; i++)
      step(($urandom % 16) != 0, ($urandom % 10) != 0, ($urandom % 5) != 0,
           3'($urandom % 8), int'($urandom % 256), bit'($urandom % 2),
           bit'($urandom % 2), "rand");

    repeat (3) @(posedge clk);
    chk("scoreboard drained", sbq.size(), 0);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
